// File: rtl/tank_sprite_draw_if.sv
// VGA pixel-stream bundle: coordinates, sync/blank timing and 12-bit colour.
// The producer of a stream uses the master modport; the consumer uses slave.
interface tank_sprite_draw_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/tank_sprite_draw.sv
// Overlays the tank sprite from a registered 48x64 image ROM onto a VGA stream.
// Three-stage pipeline keeps timing, counts and colour aligned with the ROM read.
module tank_sprite_draw #(
    parameter int          WIDTH       = 48,
    parameter int          HEIGHT      = 64,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    tank_sprite_draw_if.slave   vin,
    tank_sprite_draw_if.master  vout,
    input  logic [10:0]         xpos,
    input  logic [10:0]         ypos,
    input  logic [11:0]         rom_rgb,
    output logic [11:0]         rom_address
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
    } stage_t;

    logic [10:0] x_lat, y_lat;
    logic        vblnk_prev;
    stage_t      d1, d2;

    logic [11:0] hc12, vc12, xl12, yl12;
    logic        in_box;
    logic [5:0]  rel_x, rel_y;

    // 12-bit compares so x_lat + WIDTH cannot wrap back onto the left edge.
    assign hc12   = {1'b0, vin.hcount};
    assign vc12   = {1'b0, vin.vcount};
    assign xl12   = {1'b0, x_lat};
    assign yl12   = {1'b0, y_lat};
    assign in_box = (hc12 >= xl12) && (hc12 < xl12 + 12'(WIDTH)) &&
                    (vc12 >= yl12) && (vc12 < yl12 + 12'(HEIGHT));
    assign rel_x  = hc12[5:0] - xl12[5:0];
    assign rel_y  = vc12[5:0] - yl12[5:0];

    // Position only moves on the rising edge of vertical blank to avoid tearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_lat      <= '0;
            y_lat      <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vin.vblnk;
            if (vin.vblnk && !vblnk_prev) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // NOTE: non-blocking assignments make d1 -> d2 -> output a true shift
    // register; blocking ones would collapse the stages into a single cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_address <= '0;
            d1          <= '0;
            d2          <= '0;
        end else begin
            rom_address <= in_box ? {rel_y, rel_x} : 12'h000;
            d1          <= {vin.hcount, vin.vcount, vin.hsync, vin.vsync,
                            vin.hblnk, vin.vblnk, vin.rgb, in_box};
            d2          <= d1;
        end
    end

    // rom_rgb arrives here aligned with d2, one clock after rom_address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vout.hcount <= '0;
            vout.vcount <= '0;
            vout.hsync  <= 1'b0;
            vout.vsync  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.rgb    <= '0;
        end else begin
            vout.hcount <= d2.hcount;
            vout.vcount <= d2.vcount;
            vout.hsync  <= d2.hsync;
            vout.vsync  <= d2.vsync;
            vout.hblnk  <= d2.hblnk;
            vout.vblnk  <= d2.vblnk;
            if (d2.hblnk || d2.vblnk)
                vout.rgb <= 12'h000;
            else if (d2.in_box && rom_rgb != TRANSPARENT)
                vout.rgb <= rom_rgb;
            else
                vout.rgb <= d2.rgb;
        end
    end

endmodule

// File: tb/tb_tank_sprite_draw.sv
// Scoreboard bench for tank_sprite_draw: directed sprite/edge cases plus random
// pixels, checked against a coordinate-level model of the sprite overlay.
module tb_tank_sprite_draw;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] xpos, ypos;
    logic [11:0] rom_rgb;
    logic [11:0] rom_address;

    tank_sprite_draw_if vin ();
    tank_sprite_draw_if vout ();

    tank_sprite_draw dut (
        .clk         (clk),
        .rst         (rst),
        .vin         (vin),
        .vout        (vout),
        .xpos        (xpos),
        .ypos        (ypos),
        .rom_rgb     (rom_rgb),
        .rom_address (rom_address)
    );

    always #5 clk = ~clk;

    // Image ROM with one clock of read latency.
    logic [11:0] rom_mem [4096];
    always @(posedge clk) rom_rgb <= rom_mem[rom_address];

    int checks = 0;
    int errors = 0;
    pix_t        exp_q  [$];
    logic [11:0] addr_q [$];

    int lat_x, lat_y;
    bit prev_vb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every clock after reset, compare outputs against the next expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (addr_q.size() > 0) check("rom_address", 32'(rom_address), 32'(addr_q.pop_front()));
                if (exp_q.size() > 0) begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("hcount_out", 32'(vout.hcount), 32'(e.hcount));
                    check("vcount_out", 32'(vout.vcount), 32'(e.vcount));
                    check("hsync_out",  32'(vout.hsync),  32'(e.hsync));
                    check("vsync_out",  32'(vout.vsync),  32'(e.vsync));
                    check("hblnk_out",  32'(vout.hblnk),  32'(e.hblnk));
                    check("vblnk_out",  32'(vout.vblnk),  32'(e.vblnk));
                    check("rgb_out",    32'(vout.rgb),    32'(e.rgb));
                end
            end
        end
    end

    // Drive one pixel now, record its expected response, then advance to the next negedge.
    task automatic pix(input int hc, input int vc, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb);
        logic [10:0] h, v;
        int          rx, ry;
        bit          inb;
        logic [11:0] a, px;
        pix_t        e;
        h = hc[10:0];
        v = vc[10:0];
        vin.hcount = h;  vin.vcount = v;
        vin.hsync = hs;  vin.vsync = vs;
        vin.hblnk = hb;  vin.vblnk = vb;
        vin.rgb   = rgb;
        rx  = int'(h) - lat_x;
        ry  = int'(v) - lat_y;
        inb = (rx >= 0) && (rx < 48) && (ry >= 0) && (ry < 64);
        a   = inb ? 12'(ry * 64 + rx) : 12'h000;
        if (hb || vb)                       px = 12'h000;
        else if (inb && rom_mem[a] != 12'h000) px = rom_mem[a];
        else                                 px = rgb;
        e = '{hcount: h, vcount: v, hsync: hs, vsync: vs, hblnk: hb, vblnk: vb, rgb: px};
        exp_q.push_back(e);
        addr_q.push_back(a);
        if (vb && !prev_vb) begin
            lat_x = int'(xpos);
            lat_y = int'(ypos);
        end
        prev_vb = vb;
        @(negedge clk);
    endtask

    task automatic pixr(input int hc, input int vc);
        pix(hc, vc, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic vblank_pulse();
        for (int i = 0; i < 4; i++) pix(0, 770 + i, 1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom));
        pixr(0, 0);
    endtask

    task automatic row(input int vc, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) pixr(h, vc);
    endtask

    // Release at a negedge; the two outputs already in the pipe are flushed zeros.
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_address"}, 32'(rom_address), 32'h0);
        check({tag, "_rgb_out"},     32'(vout.rgb),    32'h0);
        check({tag, "_hcount_out"},  32'(vout.hcount), 32'h0);
        check({tag, "_vcount_out"},  32'(vout.vcount), 32'h0);
        check({tag, "_syncs"},       32'({vout.hsync, vout.vsync}), 32'h0);
        check({tag, "_blanks"},      32'({vout.hblnk, vout.vblnk}), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            rom_mem[i] = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
        rom_mem[12'h000] = 12'h000;
        rom_mem[12'h041] = 12'hABC;
        rom_mem[12'h082] = 12'hFFF;
        rom_mem[12'hFEF] = 12'h123;

        rst = 1'b0;
        lat_x = 0; lat_y = 0; prev_vb = 1'b0;
        xpos = 11'd100; ypos = 11'd50;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        #2;
        check_all_zero("reset");
        release_reset();

        // Sprite sits at (0,0) until the first vblank edge, then moves to (100,50).
        row(0, 0, 50);
        row(63, 44, 50);
        row(64, 0, 4);
        vblank_pulse();
        row(50, 98, 149);
        pix(147, 113, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
        pix(147, 114, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);

        // Transparency, opaque colour, blanking override.
        pix(100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        pix(101, 51, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        pix(102, 52, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);

        // Single-cycle sync pulses ride through with the pixel.
        pixr(120, 60);
        pix(121, 60, 1'b1, 1'b0, 1'b0, 1'b0, 12'h321);
        pixr(122, 60);
        pix(123, 60, 1'b0, 1'b1, 1'b0, 1'b0, 12'h321);
        pixr(124, 60);

        // Right-edge clipping with no wrap to the left edge.
        xpos = 11'd1000; ypos = 11'd10;
        vblank_pulse();
        row(20, 990, 1023);
        row(20, 0, 60);

        // Position change outside vblank waits for the next frame.
        xpos = 11'd200; ypos = 11'd60;
        vblank_pulse();
        row(70, 195, 250);
        xpos = 11'd300;
        row(71, 195, 250);
        row(72, 290, 350);
        vblank_pulse();
        row(70, 195, 250);
        row(72, 290, 350);

        // Held vblank must not re-sample the position.
        xpos = 11'd400;
        for (int i = 0; i < 6; i++) begin
            pix(0, 780, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
            xpos = 11'(500 + i);
        end
        row(80, 395, 452);

        // Randomised traffic around the current sprite box.
        for (int n = 0; n < 1500; n++) begin
            int hc, vc;
            if ($urandom_range(199) == 0) begin
                xpos = 11'($urandom_range(1100));
                ypos = 11'($urandom_range(800));
                vblank_pulse();
            end
            hc = lat_x + int'($urandom_range(63)) - 8;
            vc = lat_y + int'($urandom_range(79)) - 8;
            pix(hc, vc, 1'($urandom), 1'($urandom),
                ($urandom_range(15) == 0), ($urandom_range(31) == 0), 12'($urandom));
        end

        // Reset in the middle of a line clears every output immediately.
        xpos = 11'd100; ypos = 11'd50;
        vblank_pulse();
        row(55, 100, 120);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        addr_q.delete();
        lat_x = 0; lat_y = 0; prev_vb = 1'b0;
        release_reset();
        row(1, 0, 50);
        vblank_pulse();
        row(55, 95, 150);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tank_sprite_draw.md
# tank_sprite_draw

Pixel-pipeline stage that reads the 48x64 tank image ROM and overlays the tank sprite onto the incoming VGA pixel stream. It sits between the background/previous draw stage and the next draw stage. It generates the 12-bit ROM address from the current screen coordinates and the tank position, consumes the ROM's registered RGB, and keys out the transparent colour. All timing signals are delayed so they stay aligned with the pixel data.

## Interface
- `WIDTH`, 48: sprite width in pixels; must be ≤ 64.
- `HEIGHT`, 64: sprite height in pixels; must be ≤ 64.
- `TRANSPARENT`, 12'h000: ROM colour that is treated as see-through.
- `clk`  in  1  pixel clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hcount_in`, `vcount_in`  in  11 each  current pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  VGA timing.
- `rgb_in`  in  12  background pixel {r,g,b}.
- `xpos`, `ypos`  in  11 each  requested sprite top-left corner.
- `rom_rgb`  in  12  ROM data, registered by the ROM one clock after `rom_address`.
- `rom_address`  out  12  {y[5:0], x[5:0]}, registered.
- `hcount_out`, `vcount_out`  out  11 each  delayed coordinates.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1 each  delayed timing.
- `rgb_out`  out  12  composited pixel.

## Operation
- Position latch:
  - `xpos`/`ypos` are sampled into `x_lat`/`y_lat` only on the cycle where `vblnk_in` = 1 and the previous `vblnk_in` = 0 (rising edge of vertical blank).
  - This prevents tearing mid-frame.
  - A `vblnk_in` held high keeps the latched values and does not re-sample.
- Stage 1 (edge k):
  - `rel_x = hcount_in - x_lat`, `rel_y = vcount_in - y_lat`, computed 12 bits wide.
  - `in_box = (hcount_in >= x_lat) && (hcount_in < x_lat + WIDTH) && (vcount_in >= y_lat) && (vcount_in < y_lat + HEIGHT)`.
  - Comparisons are 12-bit unsigned, so `x_lat + WIDTH` never wraps.
  - `rom_address <= in_box ? {rel_y[5:0], rel_x[5:0]} : 12'h000`.
  - `in_box`, timing, counts and `rgb_in` are registered into delay stage d1.
- Stage 2 (edge k+1): the ROM presents `rom_rgb`; d1 shifts into d2.
- Stage 3 (edge k+2), registered output:
  - If `hblnk_d2 | vblnk_d2`: `rgb_out = 12'h000`.
  - Else if `in_box_d2 && rom_rgb != TRANSPARENT`: `rgb_out = rom_rgb`.
  - Else: `rgb_out = rgb_in_d2`.
- Timing and count outputs are the d2 values registered on the same edge.
- Sprite partially off-screen (x_lat + WIDTH > 1023 or beyond visible area):
  - Only the on-screen part is drawn.
  - There is no wrap to the left edge.
- `x_lat`/`y_lat` values ≥ 2048 are impossible (11-bit). Values beyond the visible area simply never hit `in_box`.

## Timing
- Latency from any input to the corresponding output: exactly 3 clocks, identical for `rgb_out`, syncs, blanks and counts.
- Latency from input coordinates to `rom_address`: 1 clock.
- `rom_rgb` is required valid 1 clock after `rom_address`, matching the ROM's registered read. No handshake; one pixel per clock, continuous.
- Reset (`rst` = 0, asynchronous):
  - All outputs, including `rom_address`, go to 0.
  - All delay stages go to 0 (`in_box` = 0, blanks = 0).
  - `x_lat` = `y_lat` = 0; the previous-`vblnk` register = 0.
- After release, the first 3 output cycles carry reset-flushed values: `rgb_out` = 0, syncs = 0.
- Reset mid-frame: the sprite reappears at (0,0) until the next rising edge of vblank, where the position is latched.
- A `vblnk_in` rising edge and an in-box pixel never coincide legally. If both occur, the new position applies from the next cycle.

## Test plan
- Reset, then stream a frame with xpos=100, ypos=50 held:
  - Sprite is drawn at (0,0) until the first vblank rising edge, then at (100,50) in the next frame.
  - hcount=100, vcount=50 drives `rom_address`=12'h000 one clock later.
  - hcount=147, vcount=113 gives address {6'd63, 6'd47} = 12'hFEF.
- Latency check:
  - A single-cycle hsync pulse at input cycle n appears at `hsync_out` exactly at cycle n+3.
  - The counts match the inputs delayed by 3.
- Transparency:
  - ROM model returns 12'h000 for in-box pixels with `rgb_in`=12'h0F0 -> `rgb_out`=12'h0F0.
  - ROM returns 12'hABC -> `rgb_out`=12'hABC.
- Blanking: an in-box pixel with `hblnk_in`=1 and ROM=12'hFFF -> `rgb_out`=12'h000.
- Edges:
  - xpos=1000, hcount 1000..1023 is drawn, and pixels after the counter wraps to hcount 0 show background.
  - hcount=xpos-1 and hcount=xpos+48 -> background.
- Mid-frame xpos change (200 -> 300) outside vblank: the rest of the frame is still drawn at 200; the next frame is drawn at 300. Asserting `rst` mid-line forces every output to 0 within the same cycle.
